contador_regressivo_m: RTL
==========================

// Module: contador_regressivo_m
// PURPOSE
//   Modulo-M down counter (countdown timer), the counting-down counterpart of the up counter.
//   A load sets the start value, and each conta pulse decrements it toward zero.
//   At zero the counter either stops (single-shot) or reloads M-1 (cyclic).
//   Used as a timeout/tempo-limite source in datapaths that already hold modulo-M up counters.
// PARAMETERS
//   M        100  counter modulus; Q always lies in [0, M-1]
//   N        7    width of Q and valor; requires 2^N >= M
//   CICLICO  0    0 = stop at zero (single-shot); 1 = reload M-1 on expiry and keep running
// PORTS
//   clock      in   1  rising-edge clock
//   zera_as_n  in   1  asynchronous reset, active-low
//   zera_s     in   1  synchronous clear: Q<=0, state PARADO
//   carrega    in   1  synchronous load of valor, state -> CONTANDO
//   valor      in   N  start value; values > M-1 are saturated to M-1
//   conta      in   1  decrement enable, evaluated only in CONTANDO
//   Q          out  N  current count
//   fim        out  1  combinational, Q==0
//   decimo     out  1  combinational, Q==M/10-1; constant 0 when M<10
//   expirou    out  1  registered one-cycle pulse on expiry
//   ativo      out  1  registered; 1 while in CONTANDO
// BEHAVIOUR
//   - Reset (zera_as_n=0, asynchronous):
//       Q=0, state PARADO, expirou=0, ativo=0
//       fim=1; decimo=0 (for M>=20)
//   - States:
//       PARADO: idle, Q held.
//       CONTANDO: counting.
//       EXPIRADO: single-shot end, Q held at 0.
//   - Priority per rising edge: zera_s > carrega > conta.
//   - zera_s (any state): Q<=0, -> PARADO, expirou<=0.
//   - carrega (any state): Q<=min(valor, M-1), -> CONTANDO, expirou<=0. conta in the same cycle is ignored.
//   - CONTANDO & conta & Q!=0: Q<=Q-1.
//   - CONTANDO & conta & Q==0 ("expiry"): expirou<=1 for exactly one cycle.
//       CICLICO=0: Q stays 0, -> EXPIRADO.
//       CICLICO=1: Q<=M-1, stays CONTANDO.
//   - A loaded value of 0 therefore expires on the first conta, not at load.
//   - conta in PARADO or EXPIRADO: no effect. Only carrega leaves those states (zera_s returns to PARADO).
//   - Latency: Q, expirou and ativo change on the clock edge after the command; fim and decimo follow Q combinationally.
//   - Arithmetic: the decrement never underflows. Q never leaves [0, M-1] and no wrap through 2^N is allowed.
//   - Mid-operation reset (async) aborts immediately. After zera_as_n rises, the next edge obeys the normal rules.
// TESTING (M=100, N=7 unless noted)
//   1. Reset asserted mid-count with Q=37 -> Q=0, ativo=0, expirou=0 without waiting for a clock edge; fim=1.
//   2. carrega, valor=5, then 6 conta cycles, CICLICO=0
//        -> Q: 5,4,3,2,1,0
//        -> expirou=1 for one cycle on the 6th conta; state EXPIRADO; Q stays 0 under further conta.
//   3. carrega, valor=120 -> Q=99; 90 conta cycles -> Q=9, decimo=1; one more conta -> Q=8, decimo=0.
//   4. CICLICO=1, carrega, valor=1, 3 conta cycles
//        -> Q: 1,0,99,98; expirou=1 once on the 99 step; ativo stays 1.
//   5. Same cycle zera_s=1, carrega=1, conta=1 with Q=40 -> Q=0, PARADO.
//      Next cycle carrega=1, conta=1, valor=7 -> Q=7 (no decrement).
//   6. In PARADO, 10 conta cycles -> Q unchanged, expirou=0.
//      carrega, valor=0 then conta -> expirou pulse, Q=0.

Source files
------------

// File: rtl/contador_regressivo_m_if.sv
// Command/status bundle of the modulo-M down counter.
// The master side issues clear/load/decrement commands. The slave side is the counter
// and reports its count and status flags.
interface contador_regressivo_m_if #(
  parameter int N = 7
);
  // Commands
  logic         zera_s;
  logic         carrega;
  logic [N-1:0] valor;
  logic         conta;

  // Status
  logic [N-1:0] Q;
  logic         fim;
  logic         decimo;
  logic         expirou;
  logic         ativo;

  modport master (
    output zera_s, carrega, valor, conta,
    input  Q, fim, decimo, expirou, ativo
  );

  modport slave (
    input  zera_s, carrega, valor, conta,
    output Q, fim, decimo, expirou, ativo
  );
endinterface

// File: rtl/contador_regressivo_m.sv
// Modulo-M down counter (countdown timer).
// A load sets the start value, clamped to M-1. Each conta decrements the count while the
// counter is running. Expiry happens on the conta that arrives while the count is already 0.
// On expiry the counter either parks in EXPIRADO (single-shot) or reloads M-1 (cyclic).
module contador_regressivo_m #(
  parameter int M       = 100,
  parameter int N       = 7,
  parameter bit CICLICO = 1'b0
) (
  input  logic                      clock,
  input  logic                      zera_as_n,
  contador_regressivo_m_if.slave    bus
);

  localparam logic [N-1:0] MAX_Q = N'(M - 1);

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    EXPIRADO = 2'd2
  } estado_t;

  estado_t      estado_q, estado_d;
  logic [N-1:0] q_q, q_d;
  logic         expirou_q, expirou_d;
  logic         ativo_q, ativo_d;
  logic [N-1:0] valor_sat;

  // Clamp the requested start value so Q can never leave [0, M-1]
  always_comb begin
    valor_sat = (bus.valor > MAX_Q) ? MAX_Q : bus.valor;
  end

  // Next-state logic. Priority is zera_s, then carrega, then conta.
  always_comb begin
    estado_d  = estado_q;
    q_d       = q_q;
    expirou_d = 1'b0;               // expirou is a single-cycle pulse
    if (bus.zera_s) begin
      q_d      = '0;
      estado_d = PARADO;
    end else if (bus.carrega) begin
      q_d      = valor_sat;
      estado_d = CONTANDO;
    end else if ((estado_q == CONTANDO) && bus.conta) begin
      if (q_q != '0) begin
        q_d = q_q - 1'b1;
      end else begin
        // Expiry: the count was already 0 when conta arrived
        expirou_d = 1'b1;
        if (CICLICO) begin
          q_d = MAX_Q;
        end else begin
          q_d      = '0;
          estado_d = EXPIRADO;
        end
      end
    end
    ativo_d = (estado_d == CONTANDO);
  end

  // State and registered outputs. The asynchronous reset aborts any count immediately.
  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      estado_q  <= PARADO;
      q_q       <= '0;
      expirou_q <= 1'b0;
      ativo_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      q_q       <= q_d;
      expirou_q <= expirou_d;
      ativo_q   <= ativo_d;
    end
  end

  assign bus.Q       = q_q;
  assign bus.fim     = (q_q == '0);
  assign bus.expirou = expirou_q;
  assign bus.ativo   = ativo_q;

  // The tenth-of-range flag only makes sense when M/10-1 is a valid count
  generate
    if (M >= 10) begin : g_decimo
      localparam logic [N-1:0] DEC_Q = N'(M / 10 - 1);
      assign bus.decimo = (q_q == DEC_Q);
    end else begin : g_sem_decimo
      assign bus.decimo = 1'b0;
    end
  endgenerate

  // The count stays within the modulus at every clock edge
  a_q_em_faixa: assert property (@(posedge clock) disable iff (!zera_as_n) q_q <= MAX_Q);

  // ativo mirrors the running state
  a_ativo_coerente: assert property (@(posedge clock) disable iff (!zera_as_n)
    ativo_q == (estado_q == CONTANDO));

endmodule
